// File: rtl/fmc_panel_pkg.sv
// Shared definitions for the front-panel controller.
//   MODE_W     : width of the display-mode register
//   mode_e     : display-mode encodings (USB, RAW, XOR, COUNT, WALK, BREATH)
//   MODE_LAST  : highest legal mode, used for wrap-around
//   mode_step  : next mode given one-cycle increment/decrement press pulses
package fmc_panel_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_USB    = 3'd0,
    MODE_RAW    = 3'd1,
    MODE_XOR    = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_WALK   = 3'd4,
    MODE_BREATH = 3'd5
  } mode_e;

  localparam mode_e MODE_LAST = MODE_BREATH;

  // Simultaneous increment and decrement cancel out.
  function automatic mode_e mode_step(input mode_e cur, input logic inc, input logic dec);
    mode_e nxt;
    nxt = cur;
    if (inc && !dec) begin
      nxt = (cur == MODE_LAST) ? MODE_USB : mode_e'(cur + 3'd1);
    end else if (dec && !inc) begin
      nxt = (cur == MODE_USB) ? MODE_LAST : mode_e'(cur - 3'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fmc_panel_ctrl_if.sv
// Front-panel signal bundle between the board pins and the controller.
//   key       : raw keys, active-low, asynchronous      (master -> slave)
//   switch    : raw switches, asynchronous              (master -> slave)
//   usb_det   : raw USB VBUS detect, asynchronous       (master -> slave)
//   led       : registered LED drive                    (slave -> master)
//   mode      : current display mode                    (slave -> master)
//   key_db    : debounced key levels, active-low        (slave -> master)
//   key_press : one-cycle pulse per debounced press     (slave -> master)
//   counter   : free-running counter                    (slave -> master)
interface fmc_panel_ctrl_if #(
  parameter int LED_W = 8,
  parameter int SW_W  = 4,
  parameter int KEY_W = 4,
  parameter int CNT_W = 32
) ();
  import fmc_panel_pkg::*;

  logic [KEY_W-1:0]  key;
  logic [SW_W-1:0]   switch;
  logic              usb_det;
  logic [LED_W-1:0]  led;
  logic [MODE_W-1:0] mode;
  logic [KEY_W-1:0]  key_db;
  logic [KEY_W-1:0]  key_press;
  logic [CNT_W-1:0]  counter;

  modport master (
    output key, switch, usb_det,
    input  led, mode, key_db, key_press, counter
  );

  modport slave (
    input  key, switch, usb_det,
    output led, mode, key_db, key_press, counter
  );

endinterface

// File: rtl/fmc_panel_ctrl_key_debounce.sv
// Single-key conditioner: 2-FF synchroniser, stability counter and
// falling-edge press pulse.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   raw_in  : raw active-low key pin
//   level_o : debounced level (idle 1)
//   press_o : one-cycle pulse, the cycle after level_o falls
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_meta    <= raw_in;
      r_sync    <= r_meta;
      r_level_d <= r_level;
      // r_level_d holds last cycle's level, so this fires once per fall.
      r_press   <= r_level_d & ~r_level;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // DEB_CYCLES consecutive differing samples: accept the new level.
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_o = r_level;
  assign press_o = r_press;

endmodule

// File: rtl/fmc_panel_ctrl.sv
// Front-panel controller: conditions keys/switches/USB detect and drives the
// LED bank from one of six display modes.
//   clk   : clock (USB domain)
//   rst_n : asynchronous active-low reset
//   bus   : fmc_panel_ctrl_if slave (raw key/switch/usb_det in;
//           led, mode, key_db, key_press, counter out)
module fmc_panel_ctrl
  import fmc_panel_pkg::*;
#(
  parameter int LED_W        = 8,
  parameter int SW_W         = 4,
  parameter int KEY_W        = 4,
  parameter int CNT_W        = 32,
  parameter int DEB_CYCLES   = 1000000,
  parameter int STEP_SH      = 22,
  parameter int PWM_SH       = 20,
  parameter int MODE_INC_KEY = 1,
  parameter int MODE_DEC_KEY = 2
) (
  input logic             clk,
  input logic             rst_n,
  fmc_panel_ctrl_if.slave bus
);

  localparam int XW = (SW_W > KEY_W) ? SW_W : KEY_W;

  logic [KEY_W-1:0] w_key_db;
  logic [KEY_W-1:0] w_key_press;

  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_s;
  logic             r_usb_meta;
  logic             r_usb_s;
  logic [CNT_W-1:0] r_counter;
  logic [LED_W-1:0] r_walk;
  mode_e            r_mode;
  logic [LED_W-1:0] r_led;

  // ---------------- key conditioning ----------------
  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_key
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (bus.key[gi]),
        .level_o(w_key_db[gi]),
        .press_o(w_key_press[gi])
      );
    end
  endgenerate

  // ---------------- switch / usb_det synchronisers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_usb_meta <= 1'b0;
      r_usb_s    <= 1'b0;
    end else begin
      r_sw_meta  <= bus.switch;
      r_sw_s     <= r_sw_meta;
      r_usb_meta <= bus.usb_det;
      r_usb_s    <= r_usb_meta;
    end
  end

  // ---------------- free-running counter and walking bit ----------------
  logic w_step;
  assign w_step = &r_counter[STEP_SH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
      r_walk    <= LED_W'(1);
    end else begin
      r_counter <= r_counter + CNT_W'(1);
      // Rotates regardless of mode so the walk stays phase-continuous.
      if (w_step) begin
        r_walk <= {r_walk[LED_W-2:0], r_walk[LED_W-1]};
      end
    end
  end

  // ---------------- breathing PWM ----------------
  logic [7:0] w_phase;
  logic [7:0] w_duty;
  logic       w_pwm_on;
  assign w_phase  = r_counter[7:0];
  assign w_duty   = r_counter[PWM_SH+7:PWM_SH];
  assign w_pwm_on = (w_phase < w_duty);

  // ---------------- LED patterns ----------------
  logic [LED_W-1:0] w_usb_pat;
  logic [LED_W-1:0] w_raw_pat;
  logic [XW-1:0]    w_xor;
  logic [LED_W-1:0] w_xor_pat;

  assign w_usb_pat = {{(LED_W-1){r_usb_s}}, ~r_usb_s};

  generate
    // {switch, key_db} resized on the MSB side to LED_W.
    for (gi = 0; gi < LED_W; gi++) begin : g_raw
      if (gi < KEY_W) begin : g_k
        assign w_raw_pat[gi] = w_key_db[gi];
      end else if (gi < KEY_W + SW_W) begin : g_s
        assign w_raw_pat[gi] = r_sw_s[gi-KEY_W];
      end else begin : g_z
        assign w_raw_pat[gi] = 1'b0;
      end
    end

    // Operands zero-extended to the wider of the two before XOR.
    for (gi = 0; gi < XW; gi++) begin : g_xor
      if (gi < SW_W && gi < KEY_W) begin : g_both
        assign w_xor[gi] = r_sw_s[gi] ^ w_key_db[gi];
      end else if (gi < SW_W) begin : g_sw
        assign w_xor[gi] = r_sw_s[gi];
      end else begin : g_kd
        assign w_xor[gi] = w_key_db[gi];
      end
    end

    // XOR result tiled across the LED bank.
    for (gi = 0; gi < LED_W; gi++) begin : g_xrep
      assign w_xor_pat[gi] = w_xor[gi % XW];
    end
  endgenerate

  // ---------------- mode FSM and registered LED drive ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_USB;
      r_led  <= '0;
    end else begin
      r_mode <= mode_step(r_mode, w_key_press[MODE_INC_KEY], w_key_press[MODE_DEC_KEY]);
      case (r_mode)
        MODE_USB:    r_led <= w_usb_pat;
        MODE_RAW:    r_led <= w_raw_pat;
        MODE_XOR:    r_led <= w_xor_pat;
        MODE_COUNT:  r_led <= r_counter[CNT_W-1 -: LED_W];
        MODE_WALK:   r_led <= r_walk;
        MODE_BREATH: r_led <= {LED_W{w_pwm_on}};
        default:     r_led <= '1;
      endcase
    end
  end

  assign bus.led       = r_led;
  assign bus.mode      = r_mode;
  assign bus.key_db    = w_key_db;
  assign bus.key_press = w_key_press;
  assign bus.counter   = r_counter;

endmodule

// File: tb/tb_fmc_panel_ctrl.sv
// Self-checking bench for fmc_panel_ctrl: directed scenarios plus random
// key/switch activity, all compared every cycle against a behavioural model.
module tb_fmc_panel_ctrl;

  localparam int LED_W   = 8;
  localparam int SW_W    = 4;
  localparam int KEY_W   = 4;
  localparam int CNT_W   = 12;  // narrowed so the counter wrap is reachable
  localparam int DEB     = 4;
  localparam int STEP_SH = 2;
  localparam int PWM_SH  = 2;
  localparam int INC_K   = 1;
  localparam int DEC_K   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmc_panel_ctrl_if #(.LED_W(LED_W), .SW_W(SW_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) bus ();

  fmc_panel_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .KEY_W(KEY_W), .CNT_W(CNT_W),
    .DEB_CYCLES(DEB), .STEP_SH(STEP_SH), .PWM_SH(PWM_SH),
    .MODE_INC_KEY(INC_K), .MODE_DEC_KEY(DEC_K)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [KEY_W-1:0] m_k1, m_ks, m_ks_last, m_db, m_db_prev, m_press;
  logic [SW_W-1:0]  m_sw1, m_sws;
  logic             m_u1, m_us;
  int               m_run [KEY_W];   // edges the synced key has held its value
  int               m_mode;
  int unsigned      m_n;             // clock edges since reset release
  logic [LED_W-1:0] m_led;

  function automatic logic [LED_W-1:0] pattern(input int mode, input logic us,
                                               input logic [SW_W-1:0] sw,
                                               input logic [KEY_W-1:0] db,
                                               input int unsigned n);
    int unsigned cnt;
    logic [LED_W-1:0] p;
    logic [3:0] x;
    cnt = n % (1 << CNT_W);
    p = '0;
    case (mode)
      0: begin
        if (us) begin p = '1; p[0] = 1'b0; end
        else    begin p = '0; p[0] = 1'b1; end
      end
      1: p = LED_W'({sw, db});
      2: begin
        x = sw ^ db;
        for (int i = 0; i < LED_W; i++) p[i] = x[i % 4];
      end
      3: p = LED_W'(cnt >> (CNT_W - LED_W));
      4: p = LED_W'(1 << ((n >> STEP_SH) % LED_W));
      5: p = ((cnt % 256) < ((cnt >> PWM_SH) % 256)) ? '1 : '0;
      default: p = '1;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    m_k1 = '1; m_ks = '1; m_ks_last = '1;
    m_sw1 = '0; m_sws = '0; m_u1 = 1'b0; m_us = 1'b0;
    m_db = '1; m_db_prev = '1; m_press = '0;
    m_mode = 0; m_n = 0; m_led = '0;
    for (int i = 0; i < KEY_W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [LED_W-1:0] led_n;
    logic [KEY_W-1:0] press_n, db_n;
    int mode_n;
    led_n  = pattern(m_mode, m_us, m_sws, m_db, m_n);
    mode_n = m_mode;
    if (m_press[INC_K] && !m_press[DEC_K])      mode_n = (m_mode + 1) % 6;
    else if (m_press[DEC_K] && !m_press[INC_K]) mode_n = (m_mode + 5) % 6;
    press_n = m_db_prev & ~m_db;
    db_n = m_db;
    for (int i = 0; i < KEY_W; i++) begin
      if (m_ks[i] == m_ks_last[i]) m_run[i]++;
      else                         m_run[i] = 1;
      if (m_ks[i] != m_db[i] && m_run[i] >= DEB) db_n[i] = m_ks[i];
    end
    m_led = led_n; m_mode = mode_n; m_press = press_n;
    m_db_prev = m_db; m_db = db_n;
    m_ks_last = m_ks; m_ks = m_k1; m_k1 = bus.key;
    m_sws = m_sw1; m_sw1 = bus.switch;
    m_us = m_u1; m_u1 = bus.usb_det;
    m_n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("led",       32'(bus.led),       32'(m_led));
      chk("mode",      32'(bus.mode),      32'(m_mode));
      chk("key_db",    32'(bus.key_db),    32'(m_db));
      chk("key_press", 32'(bus.key_press), 32'(m_press));
      chk("counter",   32'(bus.counter),   32'(m_n % (1 << CNT_W)));
    end
  end

  // ---------------- stimulus ----------------
  int pc1 = 0;  // key_press[1] pulses seen

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.key_press[1]) pc1++;
    end
  endtask

  task automatic press_release(input int k);
    bus.key[k] = 1'b0;
    step(12);
    bus.key[k] = 1'b1;
    step(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    bus.key = 4'hF; bus.switch = 4'hA; bus.usb_det = 1'b1;
    rst_n = 1'b0;
    step(3);
    // 1. reset values and USB mode
    chk("rst_led",    32'(bus.led), 32'h0);
    chk("rst_mode",   32'(bus.mode), 32'h0);
    chk("rst_key_db", 32'(bus.key_db), 32'hF);
    rst_n = 1'b1;
    step(4);
    chk("usb_led",       32'(bus.led), 32'hFE);
    chk("model_usb_led", 32'(m_led), 32'hFE);

    // 2. short bounce ignored, held press steps once
    pc1 = 0;
    bus.key[1] = 1'b0; step(3); bus.key[1] = 1'b1; step(10);
    chk("bounce_mode",  32'(bus.mode), 32'd0);
    chk("bounce_press", 32'(pc1), 32'd0);
    bus.key[1] = 1'b0; step(20);
    chk("held_press", 32'(pc1), 32'd1);
    chk("held_mode",  32'(bus.mode), 32'd1);
    bus.key[1] = 1'b1; step(12);
    press_release(1);
    chk("repress_mode", 32'(bus.mode), 32'd2);

    // 3. RAW and XOR patterns
    press_release(2);
    chk("mode_raw", 32'(bus.mode), 32'd1);
    bus.key[3] = 1'b0; step(10);
    chk("raw_key_db",    32'(bus.key_db), 32'h7);
    chk("raw_led",       32'(bus.led), 32'hA7);
    chk("model_raw_led", 32'(m_led), 32'hA7);
    press_release(1);
    chk("mode_xor",      32'(bus.mode), 32'd2);
    chk("xor_led",       32'(bus.led), 32'hDD);
    chk("model_xor_led", 32'(m_led), 32'hDD);

    // 4. wrap-around and simultaneous presses
    press_release(2); press_release(2); press_release(2);
    chk("wrap_dec_mode", 32'(bus.mode), 32'd5);
    press_release(1);
    chk("wrap_inc_mode", 32'(bus.mode), 32'd0);
    press_release(2);
    chk("dec_mode", 32'(bus.mode), 32'd5);
    bus.key[1] = 1'b0; bus.key[2] = 1'b0; step(20);
    chk("both_mode", 32'(bus.mode), 32'd5);
    bus.key = 4'hF; step(12);

    // 5. walking LED and counter wrap
    press_release(2);
    chk("mode_walk", 32'(bus.mode), 32'd4);
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      if (bus.led == 8'h80) found = 1; else step(1);
    end
    chk("walk_find80", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (bus.led != 8'h80) found = 1; else step(1);
    end
    chk("walk_leave80", 32'(found), 32'd1);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("walk_%0d", j), 32'(bus.led), 32'(1 << (j % 8)));
      step(4);
    end
    press_release(2);
    chk("mode_count", 32'(bus.mode), 32'd3);
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      if (bus.counter == CNT_W'((1 << CNT_W) - 1)) found = 1; else step(1);
    end
    chk("cnt_find_max", 32'(found), 32'd1);
    step(1);
    chk("cnt_wrap",     32'(bus.counter), 32'd0);
    chk("cnt_led_max",  32'(bus.led), 32'hFF);
    step(1);
    chk("cnt_led_zero", 32'(bus.led), 32'h00);

    // 6. reset in the middle of a press
    bus.key[1] = 1'b0; step(2);
    rst_n = 1'b0; step(2);
    rst_n = 1'b1;
    chk("rst_mid_db", 32'(bus.key_db[1]), 32'd1);
    pc1 = 0;
    step(20);
    chk("rst_mid_press", 32'(pc1), 32'd1);
    chk("rst_mid_mode",  32'(bus.mode), 32'd1);
    bus.key[1] = 1'b1; step(12);

    // random activity
    for (int it = 0; it < 400; it++) begin
      int r, k;
      r = $urandom_range(0, 4);
      if (r == 0) begin
        bus.switch  = SW_W'($urandom);
        bus.usb_det = 1'($urandom_range(0, 1));
      end else if (r == 4) begin
        bus.key[INC_K] = ~bus.key[INC_K];
        bus.key[DEC_K] = ~bus.key[DEC_K];
      end else begin
        k = $urandom_range(0, KEY_W - 1);
        bus.key[k] = ~bus.key[k];
      end
      step($urandom_range(1, 10));
    end
    bus.key = 4'hF; step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
